// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester output arbiter.
package mux_arb_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int CNT_W         = 4;

    localparam logic SRC_T = 1'b0;
    localparam logic SRC_E = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_T = 2'd1,
        OWN_E = 2'd2
    } owner_e;

endpackage

// File: rtl/mux_arb_select.sv
// Combinational grant selection: hold the current owner until its burst cap,
// otherwise grant by validity with the priority bit breaking ties.
module mux_arb_select
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  owner_e           owner,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             prio,
    input  logic             t_valid,
    input  logic             e_valid,
    output logic             sel_t,
    output logic             sel_e,
    output logic             hold
);

    logic under_cap;

    always_comb begin
        sel_t     = 1'b0;
        sel_e     = 1'b0;
        hold      = 1'b0;
        under_cap = burst_cnt < CNT_W'(MAX_BURST);
        if (owner == OWN_T && t_valid && under_cap) begin
            sel_t = 1'b1;
            hold  = 1'b1;
        end else if (owner == OWN_E && e_valid && under_cap) begin
            sel_e = 1'b1;
            hold  = 1'b1;
        end else if (t_valid && e_valid) begin
            sel_e = prio;
            sel_t = !prio;
        end else begin
            sel_t = t_valid;
            sel_e = e_valid;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter with bounded bursts feeding a one-entry output
// register; the register reloads in the same cycle it drains.
module mux2_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t_data,
    input  logic             t_valid,
    output logic             t_ready,
    input  logic [WIDTH-1:0] e_data,
    input  logic             e_valid,
    output logic             e_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
);

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    logic sel_t, sel_e, hold;
    logic load, xfer;

    mux_arb_select #(
        .MAX_BURST (MAX_BURST)
    ) u_select (
        .owner     (owner_q),
        .burst_cnt (burst_cnt_q),
        .prio      (prio_q),
        .t_valid   (t_valid),
        .e_valid   (e_valid),
        .sel_t     (sel_t),
        .sel_e     (sel_e),
        .hold      (hold)
    );

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        prio_d      = prio_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        load        = !out_valid_q || out_ready;
        xfer        = load && (sel_t || sel_e);
        if (load) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_src_d   = sel_e ? SRC_E : SRC_T;
                out_data_d  = sel_e ? e_data : t_data;
                if (hold) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else begin
                    owner_d     = sel_e ? OWN_E : OWN_T;
                    burst_cnt_d = CNT_W'(1);
                    // Fresh grant hands preference to the other side.
                    prio_d      = sel_t;
                end
            end else begin
                owner_d     = IDLE;
                burst_cnt_d = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= IDLE;
            burst_cnt_q <= '0;
            prio_q      <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            prio_q      <= prio_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign t_ready   = !rst && load && sel_t;
    assign e_ready   = !rst && load && sel_e;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter with a beat scoreboard; a second instance
// with MAX_BURST = 1 shares the inputs for the alternation case.
module tb_mux2_arbiter;
    import mux_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] t_data, e_data;
    logic       t_valid, e_valid, out_ready;
    logic       t_ready, e_ready, out_valid, out_src;
    logic [7:0] out_data;
    logic       t_ready1, e_ready1, out_valid1, out_src1;
    logic [7:0] out_data1;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
        .e_data(e_data), .e_valid(e_valid), .e_ready(e_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src)
    );

    mux2_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready1),
        .e_data(e_data), .e_valid(e_valid), .e_ready(e_ready1),
        .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_src(out_src1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a beat consumed before the edge is scored.
    task automatic cyc();
        logic [8:0] exp;
        #1;
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow obs=%0h exp=none",
                       {out_src, out_data});
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("sb_beat", {23'd0, out_src, out_data}, {23'd0, exp});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [8:0] seq_b4;
        logic [7:0] d;
        seq_b4    = 9'b0_1111_0000;
        rst       = 1'b1;
        t_data    = 8'h00;
        e_data    = 8'h00;
        t_valid   = 1'b1;
        e_valid   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_t_ready", t_ready, 0);
        chk("rst_burst", dut.burst_cnt_q, 0);
        rst = 1'b0;

        // T only, one beat per cycle
        for (int i = 1; i <= 3; i++) begin
            d = 8'(i * 8'h11);
            t_data = d;
            #1;
            chk("t_only_ready", t_ready, 1);
            sb.push_back({SRC_T, d});
            cyc();
            chk("t_only_valid", out_valid, 1);
            chk("t_only_data", out_data, d);
            chk("t_only_src", out_src, 0);
        end
        t_valid = 1'b0;
        cyc();
        chk("t_only_idle", out_valid, 0);

        // Both valid, burst cap of 4
        do_reset();
        t_valid = 1'b1;
        e_valid = 1'b1;
        t_data  = 8'h10;
        e_data  = 8'h20;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(seq_b4[i] ? {SRC_E, 8'h20} : {SRC_T, 8'h10});
            cyc();
            chk("burst4_src", out_src, seq_b4[i]);
        end
        t_valid = 1'b0;
        e_valid = 1'b0;
        cyc();

        // Stall holds the beat, then drains and reloads together
        do_reset();
        out_ready = 1'b0;
        t_valid   = 1'b1;
        t_data    = 8'hA5;
        sb.push_back({SRC_T, 8'hA5});
        cyc();
        t_data  = 8'hB6;
        e_valid = 1'b1;
        e_data  = 8'hC7;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_t_ready", t_ready, 0);
            chk("stall_e_ready", e_ready, 0);
            cyc();
            chk("stall_data", out_data, 8'hA5);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_t_ready", t_ready, 1);
        sb.push_back({SRC_T, 8'hB6});
        cyc();
        chk("drain_valid", out_valid, 1);
        chk("drain_data", out_data, 8'hB6);
        t_valid = 1'b0;
        e_valid = 1'b0;
        cyc();

        // Owner T drops after two beats, E takes over
        do_reset();
        t_valid = 1'b1;
        e_valid = 1'b1;
        e_data  = 8'h41;
        t_data  = 8'h31;
        sb.push_back({SRC_T, 8'h31});
        cyc();
        t_data = 8'h32;
        sb.push_back({SRC_T, 8'h32});
        cyc();
        t_valid = 1'b0;
        sb.push_back({SRC_E, 8'h41});
        cyc();
        chk("drop_src", out_src, 1);
        chk("drop_burst", dut.burst_cnt_q, 1);
        chk("drop_prio", dut.prio_q, 0);
        chk("drop_owner", dut.owner_q, OWN_E);
        e_valid = 1'b0;
        cyc();

        // Reset pulse mid-burst
        do_reset();
        t_valid = 1'b1;
        e_valid = 1'b1;
        t_data  = 8'h71;
        e_data  = 8'h81;
        sb.push_back({SRC_T, 8'h71});
        cyc();
        t_data = 8'h72;
        sb.push_back({SRC_T, 8'h72});
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_t_ready", t_ready, 0);
        chk("midrst_e_ready", e_ready, 0);
        cyc();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_owner", dut.owner_q, IDLE);
        chk("midrst_e_ready2", e_ready, 0);
        sb.delete();
        rst = 1'b0;
        #1;
        chk("postrst_t_ready", t_ready, 1);
        chk("postrst_e_ready", e_ready, 0);
        sb.push_back({SRC_T, 8'h72});
        cyc();
        chk("postrst_src", out_src, 0);
        chk("postrst_valid", out_valid, 1);
        t_valid = 1'b0;
        e_valid = 1'b0;
        cyc();

        // MAX_BURST = 1 alternates; the 4-cap instance is scored alongside
        do_reset();
        t_valid = 1'b1;
        e_valid = 1'b1;
        t_data  = 8'h51;
        e_data  = 8'h61;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(i < 4 ? {SRC_T, 8'h51} : {SRC_E, 8'h61});
            cyc();
            chk("alt_valid", out_valid1, 1);
            chk("alt_src", out_src1, i % 2);
        end
        t_valid = 1'b0;
        e_valid = 1'b0;
        cyc();
        cyc();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
